mult_8x8: RTL and testbench
===========================

MULT_8X8 -- requirements
Module: mult_8x8

Interface
REQ-001 The module SHALL have parameter SEG_ACTIVE_LOW, default 0, meaning segment polarity (0: 1 = lit; 1: 0 = lit).
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port arst, input, 1 bit: asynchronous reset, active-high.
REQ-004 The module SHALL have port start, input, 1 bit: synchronous level, sampled on the rising clk edge; requests a new multiplication.
REQ-005 The module SHALL have ports dataa and datab, inputs, 8 bits each: unsigned operands, held stable from the start edge until done_flag is set.
REQ-006 The module SHALL have port product8x8_out, output, 16 bits: unsigned accumulator (product) register.
REQ-007 The module SHALL have port done_flag, output, 1 bit: high while in state CALC_DONE.
REQ-008 The module SHALL have ports seg_a through seg_g, outputs, 1 bit each: seven-segment code of the current state.

Function
REQ-009 The module SHALL compute dataa*datab as the sum of four 4x4 partial products using one combinational 4x4 multiplier, one 16-bit adder and a 2-bit cycle counter.
REQ-010 The FSM SHALL have states IDLE, LSB, MID, MSB, CALC_DONE and ERR, encoded in 3 bits.
REQ-011 In IDLE or CALC_DONE, start=1 at a clk edge SHALL clear product8x8_out to 0, clear the counter and go to LSB; start=0 keeps the current state.
REQ-012 In LSB with start=0, the clk edge SHALL add (a[3:0]*b[3:0])<<0, set counter=1 and go to MID.
REQ-013 In MID with start=0 and counter=1, the clk edge SHALL add (a[7:4]*b[3:0])<<4, set counter=2 and stay in MID.
REQ-014 In MID with start=0 and counter=2, the clk edge SHALL add (a[3:0]*b[7:4])<<4, set counter=3 and go to MSB.
REQ-015 In MSB with start=0, the clk edge SHALL add (a[7:4]*b[7:4])<<8 and go to CALC_DONE.
REQ-016 Latency SHALL be 4 clk edges after the start-sampling edge, after which done_flag=1 and product8x8_out holds the exact product.
REQ-017 start=1 in LSB, MID or MSB SHALL move the FSM to ERR with the accumulator held.
REQ-018 In ERR, start=1 SHALL keep ERR and start=0 SHALL go to IDLE; the accumulator SHALL be held in ERR.
REQ-019 The adder SHALL be 16 bits and never overflow, since the maximum product is 65025.
REQ-020 product8x8_out SHALL be held in IDLE, CALC_DONE and ERR unless cleared by a start edge.
REQ-021 Segments SHALL display '0' for IDLE, '1' for LSB, '2' for MID, '3' for MSB, '4' for CALC_DONE and 'E' for ERR, with standard a-g mapping.

Reset
REQ-022 arst=1 SHALL immediately force state IDLE, product8x8_out=0, counter=0, done_flag=0 and the display to '0', regardless of clk.
REQ-023 arst asserted mid-operation SHALL abort the operation; after release the module SHALL wait in IDLE for start.

Configuration
REQ-024 Macro MULT_8X8_SEG_EN defined SHALL include the seven-segment decoder.
REQ-025 Without MULT_8X8_SEG_EN, seg_a through seg_g SHALL be tied to the unlit level and the multiplier function SHALL be unchanged.

Structure
REQ-026 Package mult_8x8_pkg SHALL hold the state enum, the shift-amount constants (0, 4, 8) and the seven-segment code constants.
REQ-027 The 4x4 multiplier SHALL be the single sub-module mult4x4 (purely combinational, 4x4 to 8 bits); the adder, counter, operand muxes and FSM SHALL be inline.

Verification
REQ-028 The bench SHALL check: dataa=100, datab=200, start pulse -> done_flag=1 four edges later, product8x8_out=20000 (0x4E20), and the display sequence 1, 2, 2, 3, 4.
REQ-029 The bench SHALL check: dataa=255, datab=255 -> product8x8_out=65025 and done_flag=1.
REQ-030 The bench SHALL check: dataa=0, datab=173 -> product8x8_out=0; then a start from CALC_DONE with 15x17 -> 255.
REQ-031 The bench SHALL check: start reasserted while in MID -> state ERR, display 'E', product held; start=0 -> IDLE.
REQ-032 The bench SHALL check: arst pulse while in MSB -> product8x8_out=0, done_flag=0 and IDLE immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/mult_8x8_pkg.sv
// Shared constants for the sequential 8x8 multiplier: FSM state codes,
// partial-product shift amounts and seven-segment glyphs.
package mult_8x8_pkg;

    // FSM state encoding (3 bits)
    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_LSB  = 3'd1;
    localparam state_t ST_MID  = 3'd2;
    localparam state_t ST_MSB  = 3'd3;
    localparam state_t ST_DONE = 3'd4;
    localparam state_t ST_ERR  = 3'd5;

    // Left-shift applied to each 4x4 partial product before accumulation
    localparam logic [3:0] SHIFT_LSB = 4'd0;
    localparam logic [3:0] SHIFT_MID = 4'd4;
    localparam logic [3:0] SHIFT_MSB = 4'd8;

    // Seven-segment glyphs, bit order {a,b,c,d,e,f,g}, 1 = lit
    localparam logic [6:0] SEG_0 = 7'b1111110;
    localparam logic [6:0] SEG_1 = 7'b0110000;
    localparam logic [6:0] SEG_2 = 7'b1101101;
    localparam logic [6:0] SEG_3 = 7'b1111001;
    localparam logic [6:0] SEG_4 = 7'b0110011;
    localparam logic [6:0] SEG_E = 7'b1001111;

endpackage

// File: rtl/mult_8x8_mult4x4.sv
// Purely combinational 4x4 unsigned multiplier producing an 8-bit result.
module mult4x4 (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    output logic [7:0] p_o
);

    assign p_o = {4'b0000, a_i} * {4'b0000, b_i};

endmodule

// File: rtl/mult_8x8.sv
// Sequential 8x8 unsigned multiplier built from one 4x4 multiplier and a
// 16-bit accumulator, summing four shifted partial products over four cycles.
// Optional feature: define MULT_8X8_SEG_EN to drive a seven-segment display
// of the current FSM state; otherwise the segments sit at the unlit level.
module mult_8x8
    import mult_8x8_pkg::*;
#(
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic        clk,
    input  logic        arst,
    input  logic        start,
    input  logic [7:0]  dataa,
    input  logic [7:0]  datab,
    output logic [15:0] product8x8_out,
    output logic        done_flag,
    output logic        seg_a,
    output logic        seg_b,
    output logic        seg_c,
    output logic        seg_d,
    output logic        seg_e,
    output logic        seg_f,
    output logic        seg_g
);

    state_t      state_q, state_d;
    logic [15:0] acc_q, acc_d;
    logic [1:0]  cnt_q, cnt_d;

    logic [3:0]  opA, opB;
    logic [3:0]  shamt;
    logic [7:0]  partial;
    logic [15:0] shifted;
    logic [6:0]  segOut;

    // Pick which nibble pair and shift the current cycle contributes
    always_comb begin
        opA   = dataa[3:0];
        opB   = datab[3:0];
        shamt = SHIFT_LSB;
        case (state_q)
            ST_MID: begin
                shamt = SHIFT_MID;
                if (cnt_q == 2'd1) begin
                    opA = dataa[7:4];
                end else begin
                    opB = datab[7:4];
                end
            end
            ST_MSB: begin
                opA   = dataa[7:4];
                opB   = datab[7:4];
                shamt = SHIFT_MSB;
            end
            default: ;
        endcase
    end

    mult4x4 u_mult4x4 (
        .a_i (opA),
        .b_i (opB),
        .p_o (partial)
    );

    assign shifted = {8'h00, partial} << shamt;

    // Next-state, accumulator and counter logic; a start while busy aborts to ERR
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    acc_d   = 16'h0000;
                    cnt_d   = 2'd0;
                    state_d = ST_LSB;
                end
            end
            ST_LSB: begin
                if (start) begin
                    state_d = ST_ERR;
                end else begin
                    acc_d   = acc_q + shifted;
                    cnt_d   = 2'd1;
                    state_d = ST_MID;
                end
            end
            ST_MID: begin
                if (start) begin
                    state_d = ST_ERR;
                end else if (cnt_q == 2'd1) begin
                    acc_d = acc_q + shifted;
                    cnt_d = 2'd2;
                end else begin
                    acc_d   = acc_q + shifted;
                    cnt_d   = 2'd3;
                    state_d = ST_MSB;
                end
            end
            ST_MSB: begin
                if (start) begin
                    state_d = ST_ERR;
                end else begin
                    acc_d   = acc_q + shifted;
                    state_d = ST_DONE;
                end
            end
            ST_ERR: begin
                if (!start) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with asynchronous reset that aborts any operation
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= ST_IDLE;
            acc_q   <= 16'h0000;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign product8x8_out = acc_q;
    assign done_flag      = (state_q == ST_DONE);

`ifdef MULT_8X8_SEG_EN
    logic [6:0] segRaw;

    // Map the current state onto its display glyph, then apply polarity
    always_comb begin
        segRaw = SEG_0;
        case (state_q)
            ST_IDLE: segRaw = SEG_0;
            ST_LSB:  segRaw = SEG_1;
            ST_MID:  segRaw = SEG_2;
            ST_MSB:  segRaw = SEG_3;
            ST_DONE: segRaw = SEG_4;
            ST_ERR:  segRaw = SEG_E;
            default: segRaw = SEG_0;
        endcase
    end

    assign segOut = SEG_ACTIVE_LOW ? ~segRaw : segRaw;
`else
    assign segOut = {7{SEG_ACTIVE_LOW}};
`endif

    assign {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g} = segOut;

endmodule

// File: tb/tb_mult_8x8.sv
// Self-checking bench for mult_8x8: a scoreboard queue holds expected products,
// a monitor pops one each time done_flag rises; per-cycle state/display checks
// run alongside the directed stimulus.
module tb_mult_8x8;
    import mult_8x8_pkg::*;

    localparam bit SEG_ACTIVE_LOW = 1'b0;

    // Glyphs written out by hand, bit order {a,b,c,d,e,f,g}
    localparam logic [6:0] GLYPH_0 = 7'b1111110;
    localparam logic [6:0] GLYPH_1 = 7'b0110000;
    localparam logic [6:0] GLYPH_2 = 7'b1101101;
    localparam logic [6:0] GLYPH_3 = 7'b1111001;
    localparam logic [6:0] GLYPH_4 = 7'b0110011;
    localparam logic [6:0] GLYPH_E = 7'b1001111;

    logic        clk;
    logic        arst;
    logic        start;
    logic [7:0]  dataa;
    logic [7:0]  datab;
    logic [15:0] product8x8_out;
    logic        done_flag;
    logic        seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g;

    int checks;
    int passes;
    logic [15:0] expQ[$];
    logic        prevDone;

    mult_8x8 #(
        .SEG_ACTIVE_LOW (SEG_ACTIVE_LOW)
    ) dut (
        .clk            (clk),
        .arst           (arst),
        .start          (start),
        .dataa          (dataa),
        .datab          (datab),
        .product8x8_out (product8x8_out),
        .done_flag      (done_flag),
        .seg_a          (seg_a),
        .seg_b          (seg_b),
        .seg_c          (seg_c),
        .seg_d          (seg_d),
        .seg_e          (seg_e),
        .seg_f          (seg_f),
        .seg_g          (seg_g)
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected segment pattern for a glyph in this build
    function automatic logic [6:0] expSeg(input logic [6:0] lit);
`ifdef MULT_8X8_SEG_EN
        return SEG_ACTIVE_LOW ? ~lit : lit;
`else
        return {7{SEG_ACTIVE_LOW}} | (lit & 7'h00);
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkState(input string name, input state_t st, input logic [6:0] glyph);
        checkOutput({name, " state"}, {13'h0, dut.state_q}, {13'h0, st});
        checkOutput({name, " seg"}, {9'h0, seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g},
                    {9'h0, expSeg(glyph)});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands with a one-cycle start pulse; returns just after the sampling edge
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        dataa = a;
        datab = b;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Monitor: every rising done_flag must match the oldest queued product
    always @(negedge clk) begin
        if (arst) begin
            prevDone = 1'b0;
        end else begin
            if (done_flag && !prevDone) begin
                if (expQ.size() == 0) begin
                    checks++;
                    $display("[TB] FAIL scoreboard: done_flag rose with product 0x%0h, expected no result", product8x8_out);
                end else begin
                    checkOutput("scoreboard product", product8x8_out, expQ.pop_front());
                end
            end
            prevDone = done_flag;
        end
    end

    // Watchdog so the run can never hang
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "[TB] timeout");
    end

    state_t     seqState[4] = '{ST_MID, ST_MID, ST_MSB, ST_DONE};
    logic [6:0] seqGlyph[4] = '{GLYPH_2, GLYPH_2, GLYPH_3, GLYPH_4};

    initial begin
        checks   = 0;
        passes   = 0;
        prevDone = 1'b0;
        arst     = 1'b1;
        start    = 1'b0;
        dataa    = 8'h00;
        datab    = 8'h00;

        // Reset state, sampled before any clock edge
        #3;
        checkOutput("reset product", product8x8_out, 16'h0000);
        checkOutput("reset done", {15'h0, done_flag}, 16'h0000);
        checkState("reset", ST_IDLE, GLYPH_0);
        @(negedge clk);
        arst = 1'b0;

        // 100 x 200 = 20000 with display sequence 1,2,2,3,4
        expQ.push_back(16'd20000);
        applyStimulus(8'd100, 8'd200);
        checkState("100x200 edge1", ST_LSB, GLYPH_1);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkState($sformatf("100x200 edge%0d", i + 2), seqState[i], seqGlyph[i]);
        end
        checkOutput("100x200 done", {15'h0, done_flag}, 16'h0001);
        checkOutput("100x200 product", product8x8_out, 16'h4E20);

        // 255 x 255 = 65025, the largest product
        expQ.push_back(16'd65025);
        applyStimulus(8'd255, 8'd255);
        for (int i = 0; i < 4; i++) tick();
        checkOutput("255x255 done", {15'h0, done_flag}, 16'h0001);
        checkOutput("255x255 product", product8x8_out, 16'd65025);

        // 0 x 173 = 0, then restart from CALC_DONE with 15 x 17 = 255
        expQ.push_back(16'd0);
        applyStimulus(8'd0, 8'd173);
        for (int i = 0; i < 4; i++) tick();
        checkOutput("0x173 product", product8x8_out, 16'd0);
        checkOutput("0x173 done", {15'h0, done_flag}, 16'h0001);
        expQ.push_back(16'd255);
        applyStimulus(8'd15, 8'd17);
        checkOutput("restart done low", {15'h0, done_flag}, 16'h0000);
        checkState("restart", ST_LSB, GLYPH_1);
        for (int i = 0; i < 4; i++) tick();
        checkOutput("15x17 product", product8x8_out, 16'd255);

        // Start reasserted in MID -> ERR with accumulator held (4*8 = 32)
        applyStimulus(8'd100, 8'd200);
        tick();
        checkState("err pre", ST_MID, GLYPH_2);
        @(negedge clk);
        start = 1'b1;
        tick();
        checkState("err enter", ST_ERR, GLYPH_E);
        checkOutput("err product held", product8x8_out, 16'd32);
        tick();
        checkState("err stay", ST_ERR, GLYPH_E);
        @(negedge clk);
        start = 1'b0;
        tick();
        checkState("err exit", ST_IDLE, GLYPH_0);
        checkOutput("err exit product", product8x8_out, 16'd32);
        checkOutput("err exit done", {15'h0, done_flag}, 16'h0000);

        // Asynchronous reset while in MSB (partial sum 225+3600+3600 = 7425)
        applyStimulus(8'd255, 8'd255);
        for (int i = 0; i < 3; i++) tick();
        checkState("arst pre", ST_MSB, GLYPH_3);
        checkOutput("arst pre product", product8x8_out, 16'd7425);
        #2;
        arst = 1'b1;
        #1;
        checkOutput("arst product", product8x8_out, 16'h0000);
        checkOutput("arst done", {15'h0, done_flag}, 16'h0000);
        checkState("arst", ST_IDLE, GLYPH_0);
        @(negedge clk);
        arst = 1'b0;
        tick();
        tick();
        checkState("arst wait", ST_IDLE, GLYPH_0);

        // Every queued product must have been consumed
        tick();
        checkOutput("scoreboard drained", 16'(expQ.size()), 16'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
